uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; legal values >= 2.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req0_valid  input  1  requester 0 (CPU stdout) has a byte.
REQ-005 SHALL have port req0_data  input  8  requester 0 byte.
REQ-006 SHALL have port req0_ready  output  1  requester 0 byte accepted this cycle.
REQ-007 SHALL have port req1_valid  input  1  requester 1 (debug channel) has a byte.
REQ-008 SHALL have port req1_data  input  8  requester 1 byte.
REQ-009 SHALL have port req1_ready  output  1  requester 1 byte accepted this cycle.
REQ-010 SHALL have port tx  output  1  serial line, idle high.
REQ-011 SHALL have port busy  output  1  frame in progress.
REQ-012 SHALL have port grant_id  output  1  index of the requester whose byte was most recently accepted.

Function
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-014 SHALL transfer a byte when reqN_valid and reqN_ready are both high in the same cycle.
REQ-015 SHALL drive reqN_ready combinationally high only when state is IDLE, reset is low, reqN_valid is high, and N is the arbitration winner.
REQ-016 SHALL assert at most one reqN_ready per cycle.
REQ-017 SHALL use round-robin arbitration with a 1-bit priority pointer: if only one requester is valid, it wins; if both are valid, the requester named by the pointer wins.
REQ-018 SHALL set the pointer to the non-winning index on each accept.
REQ-019 SHALL, on accept, latch the data byte, set grant_id to the winner, and enter START in the next cycle.
REQ-020 SHALL drive tx low for exactly CLKS_PER_BIT cycles in START, then move to DATA.
REQ-021 SHALL shift the 8 data bits out LSB first in DATA, each held for CLKS_PER_BIT cycles, using a 3-bit bit index, then move to STOP.
REQ-022 SHALL drive tx high for CLKS_PER_BIT cycles in STOP, then return to IDLE.
REQ-023 SHALL make a frame exactly 10*CLKS_PER_BIT cycles from the first START cycle to the first IDLE cycle.
REQ-024 SHALL register tx (no combinational path from inputs) and hold it high in IDLE.
REQ-025 SHALL drive busy high iff state is not IDLE.
REQ-026 SHALL allow the earliest next accept in the first IDLE cycle after STOP, giving no idle gap beyond that cycle.
REQ-027 SHALL not latch requests: a valid deasserted before ready is dropped; requesters hold data stable while valid.
REQ-028 SHALL ignore valid and data changes during START, DATA and STOP.
REQ-029 SHALL use a baud counter wide enough for CLKS_PER_BIT-1 that wraps to 0 at each bit boundary.

Reset
REQ-030 SHALL, while reset is high, force state to IDLE, tx to 1, busy to 0, grant_id to 0, pointer to 0 (requester 0 priority), and the baud counter and bit index to 0.
REQ-031 SHALL hold req0_ready and req1_ready at 0 while reset is high.
REQ-032 SHALL abort any frame in progress on reset mid-frame, with tx = 1 from the next cycle.

Verification (CLKS_PER_BIT=4)
REQ-033 SHALL cover: reset held 3 cycles with both valids high -> tx=1, busy=0, both readies 0, grant_id=0.
REQ-034 SHALL cover: req0 0xA5 alone -> req0_ready high for 1 cycle; tx bits 0,1,0,1,0,0,1,0,1,1, each 4 cycles; busy high 40 cycles; grant_id=0.
REQ-035 SHALL cover: both valid in the same cycle, req0 0x55, req1 0xAA -> 0x55 sent first (grant_id=0), then 0xAA starting in the first IDLE cycle after (grant_id=1).
REQ-036 SHALL cover: req1 valid continuously with 0x3C, req0 idle -> two back-to-back frames; second accept in the first IDLE cycle after frame 1; grant_id=1 both times.
REQ-037 SHALL cover: both continuously valid for 4 frames -> grants alternate 0,1,0,1.
REQ-038 SHALL cover: reset asserted during DATA bit 3 -> next cycle tx=1, busy=0; after release, both valid -> req0 wins.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Two-requester UART transmitter: round-robin arbitration picks one byte per
// frame and serialises it as 8N1 (start, 8 data bits LSB first, stop).
module uart_tx_arbiter #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       tx,
    output logic       busy,
    output logic       grant_id
);

    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [BW-1:0] baud, baud_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    data_q, data_n;
    logic          tx_n;
    logic          grant_n;
    logic          ptr, ptr_n;
    logic          win1;
    logic          accept;
    logic          bit_done;

    // Handshake: a byte moves when reqN_valid and reqN_ready are high in the
    // same cycle; ready is offered only in IDLE, only to the winner, never in reset.
    always_comb begin
        win1     = req1_valid & (~req0_valid | ptr);
        accept   = (state == IDLE) & ~reset & (req0_valid | req1_valid);
        bit_done = (baud == BAUD_LAST);
    end

    assign req0_ready = accept & ~win1;
    assign req1_ready = accept & win1;
    assign busy       = (state != IDLE);

    always_comb begin
        state_n   = state;
        baud_n    = baud;
        bit_idx_n = bit_idx;
        data_n    = data_q;
        tx_n      = tx;
        grant_n   = grant_id;
        ptr_n     = ptr;
        case (state)
            IDLE: begin
                tx_n      = 1'b1;
                baud_n    = '0;
                bit_idx_n = 3'd0;
                if (accept) begin
                    state_n = START;
                    data_n  = win1 ? req1_data : req0_data;
                    grant_n = win1;
                    ptr_n   = ~win1;
                    tx_n    = 1'b0;
                end
            end
            START: begin
                baud_n = bit_done ? '0 : baud + BW'(1);
                if (bit_done) begin
                    state_n = DATA;
                    tx_n    = data_q[0];
                end
            end
            DATA: begin
                baud_n = bit_done ? '0 : baud + BW'(1);
                if (bit_done) begin
                    if (bit_idx == 3'd7) begin
                        state_n   = STOP;
                        bit_idx_n = 3'd0;
                        tx_n      = 1'b1;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        tx_n      = data_q[bit_idx + 3'd1];
                    end
                end
            end
            STOP: begin
                baud_n = bit_done ? '0 : baud + BW'(1);
                if (bit_done) begin
                    state_n = IDLE;
                    tx_n    = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

    // tx is computed one cycle ahead so the registered line matches the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud     <= '0;
            bit_idx  <= 3'd0;
            data_q   <= 8'h00;
            tx       <= 1'b1;
            grant_id <= 1'b0;
            ptr      <= 1'b0;
        end else begin
            state    <= state_n;
            baud     <= baud_n;
            bit_idx  <= bit_idx_n;
            data_q   <= data_n;
            tx       <= tx_n;
            grant_id <= grant_n;
            ptr      <= ptr_n;
        end
    end

endmodule
